// File: rtl/stage4_fast_pack_pkg.sv
// Shared widths, state encoding and length clamp for the stage-4 fast message packer.
package stage4_fast_pack_pkg;

  localparam int FAST_MSG_BITS  = 344;
  localparam int FAST_LEN_BITS  = 8;
  localparam int FAST_MSG_BYTES = FAST_MSG_BITS / 8;
  localparam int OFF_W          = 6;

  typedef enum logic {
    S4_IDLE = 1'b0,
    S4_SEND = 1'b1
  } s4_state_t;

  function automatic logic len_too_long(input logic [FAST_LEN_BITS-1:0] len);
    return len > FAST_LEN_BITS'(FAST_MSG_BYTES);
  endfunction

  // Out-of-range lengths saturate to a full message rather than wrapping.
  function automatic logic [OFF_W-1:0] clamp_len(input logic [FAST_LEN_BITS-1:0] len);
    if (len_too_long(len)) return OFF_W'(FAST_MSG_BYTES);
    return len[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/stage4_byte_sel.sv
// Picks byte `off` (byte 0 = most significant) out of one held fast message.
module stage4_byte_sel
  import stage4_fast_pack_pkg::*;
(
  input  logic [FAST_MSG_BITS-1:0] msg,
  input  logic [OFF_W-1:0]         off,
  output logic [7:0]               sel_byte
);

  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < FAST_MSG_BYTES; k++) begin
      if (off == OFF_W'(k)) sel_byte = msg[FAST_MSG_BITS-1-8*k -: 8];
    end
  end

endmodule

// File: rtl/stage4_fast_pack.sv
// Serialises a three-message fast group onto a byte valid/ready stream.
// Define STAGE4_FAST_STATS_EN to add the msg_cnt/byte_cnt statistics ports.
//
// state   | meaning
// S4_IDLE | ready for a group; all-zero-length groups are absorbed here
// S4_SEND | streaming byte `off` of held message `idx`
module stage4_fast_pack
  import stage4_fast_pack_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FAST_MSG_BITS-1:0] msg_1,
  input  logic [FAST_MSG_BITS-1:0] msg_2,
  input  logic [FAST_MSG_BITS-1:0] msg_3,
  input  logic [FAST_LEN_BITS-1:0] len_1,
  input  logic [FAST_LEN_BITS-1:0] len_2,
  input  logic [FAST_LEN_BITS-1:0] len_3,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     out_last,
  output logic                     len_err
`ifdef STAGE4_FAST_STATS_EN
  ,
  output logic [31:0]              msg_cnt,
  output logic [31:0]              byte_cnt
`endif
);

  s4_state_t                state;
  logic [FAST_MSG_BITS-1:0] msg_q [3];
  logic [OFF_W-1:0]         len_q [3];
  logic [1:0]               idx;
  logic [OFF_W-1:0]         off;

  logic [FAST_MSG_BITS-1:0] msg_cur;
  logic [OFF_W-1:0]         len_cur;
  logic [7:0]               sel_byte;
  logic                     has_next;
  logic [1:0]               next_idx;
  logic                     sending;
  logic                     at_eop;
  logic [OFF_W-1:0]         cl_1, cl_2, cl_3;

  assign cl_1 = clamp_len(len_1);
  assign cl_2 = clamp_len(len_2);
  assign cl_3 = clamp_len(len_3);

  always_comb begin
    case (idx)
      2'd0:    begin msg_cur = msg_q[0]; len_cur = len_q[0]; end
      2'd1:    begin msg_cur = msg_q[1]; len_cur = len_q[1]; end
      default: begin msg_cur = msg_q[2]; len_cur = len_q[2]; end
    endcase
  end

  // Later messages with zero length are skipped entirely.
  always_comb begin
    has_next = 1'b0;
    next_idx = 2'd2;
    case (idx)
      2'd0: begin
        if (len_q[1] != '0) begin
          has_next = 1'b1;
          next_idx = 2'd1;
        end else if (len_q[2] != '0) begin
          has_next = 1'b1;
          next_idx = 2'd2;
        end
      end
      2'd1: has_next = (len_q[2] != '0);
      default: has_next = 1'b0;
    endcase
  end

  stage4_byte_sel u_byte_sel (
    .msg      (msg_cur),
    .off      (off),
    .sel_byte (sel_byte)
  );

  assign sending   = (state == S4_SEND);
  assign at_eop    = (off == len_cur - OFF_W'(1));
  assign in_ready  = (state == S4_IDLE);
  assign out_valid = sending;
  assign out_data  = sending ? sel_byte : 8'h00;
  assign out_sop   = sending & (off == '0);
  assign out_eop   = sending & at_eop;
  assign out_last  = sending & at_eop & ~has_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S4_IDLE;
      idx     <= '0;
      off     <= '0;
      len_err <= 1'b0;
      for (int m = 0; m < 3; m++) begin
        msg_q[m] <= '0;
        len_q[m] <= '0;
      end
    end else begin
      case (state)
        S4_IDLE: begin
          if (in_valid) begin
            msg_q[0] <= msg_1;
            msg_q[1] <= msg_2;
            msg_q[2] <= msg_3;
            len_q[0] <= cl_1;
            len_q[1] <= cl_2;
            len_q[2] <= cl_3;
            off      <= '0;
            len_err  <= len_err | len_too_long(len_1) | len_too_long(len_2)
                        | len_too_long(len_3);
            if (cl_1 != '0) begin
              idx   <= 2'd0;
              state <= S4_SEND;
            end else if (cl_2 != '0) begin
              idx   <= 2'd1;
              state <= S4_SEND;
            end else if (cl_3 != '0) begin
              idx   <= 2'd2;
              state <= S4_SEND;
            end
          end
        end
        S4_SEND: begin
          if (out_ready) begin
            if (!at_eop) begin
              off <= off + OFF_W'(1);
            end else if (has_next) begin
              idx <= next_idx;
              off <= '0;
            end else begin
              state <= S4_IDLE;
            end
          end
        end
        default: state <= S4_IDLE;
      endcase
    end
  end

`ifdef STAGE4_FAST_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_cnt  <= '0;
      byte_cnt <= '0;
    end else if (sending && out_ready) begin
      byte_cnt <= byte_cnt + 32'd1;
      if (at_eop) msg_cnt <= msg_cnt + 32'd1;
    end
  end
`endif

endmodule
